// File: rtl/frac_logic_klut_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : frac_logic_klut_cfg
//  Description : Fracturable K-input LUT with a serial configuration chain.
//                A CFG_LEN-bit shift register holds a 2**K-entry truth table
//                (cfg[0 .. 2**K-1]) followed by one mode-select bit
//                (cfg[2**K]). With sel=1, out0 is the full K-input LUT
//                output. With sel=0, the LUT splits into two (K-1)-input
//                halves that share the low K-1 inputs: out0 reads the lower
//                half and out1 reads the upper half. out1 always reads the
//                upper half. Both outputs are forced low until exactly
//                CFG_LEN bits have been loaded since the last reset or
//                restart.
//
//  Ports       : pReset         async active-high reset of all config state
//                prog_clk       single clock, rising edge
//                ccff_en        shift enable for the configuration chain
//                cfg_restart    synchronous clear of the load counter only
//                ccff_head      serial configuration data in
//                frac_logic_in  LUT inputs, [0] is the index LSB
//                frac_logic_out {out0, out1}, gated by cfg_done
//                ccff_tail      serial configuration data out (cfg[CFG_LEN-1])
//                cfg_done       exactly CFG_LEN bits loaded
//
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_logic_klut_cfg #(
    parameter int K       = 4,
    parameter int CFG_LEN = 2**K + 1
) (
    input  logic         pReset,
    input  logic         prog_clk,
    input  logic         ccff_en,
    input  logic         cfg_restart,
    input  logic         ccff_head,
    input  logic [0:K-1] frac_logic_in,
    output logic [0:1]   frac_logic_out,
    output logic         ccff_tail,
    output logic         cfg_done
);

    localparam int c_LUT_SIZE = 2**K;
    localparam int c_CNT_W    = $clog2(CFG_LEN + 1);

    // Counter values of interest: a full load, and one past it, which marks
    // an overshift and latches until reset or restart.
    localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(CFG_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_OVER = c_CNT_W'(CFG_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Bit i of r_cfg_q is cfg[i]. cfg[0] receives ccff_head, and
    // cfg[CFG_LEN-1] is both the select bit and the serial output.
    logic [CFG_LEN-1:0] r_cfg_q;
    logic [CFG_LEN-1:0] w_cfg_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_cfg_d = r_cfg_q;
        if (ccff_en) begin
            w_cfg_d = {r_cfg_q[CFG_LEN-2:0], ccff_head};
        end
    end

    // A restart together with an enable counts the bit that is shifted in on
    // that same edge. This way the next CFG_LEN-1 shifts complete a load.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (cfg_restart) begin
            w_cnt_d = ccff_en ? c_CNT_ONE : '0;
        end else if (ccff_en && (r_cnt_q != c_CNT_OVER)) begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_cfg_q <= '0;
            r_cnt_q <= '0;
        end else begin
            r_cfg_q <= w_cfg_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // LUT read path (purely combinational)
    // ------------------------------------------------------------------------
    // The input port is declared ascending with [0] as the LSB. Re-pack it
    // into a conventional descending index vector.
    logic [K-1:0] w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_idx
            assign w_idx[gi] = frac_logic_in[gi];
        end
    endgenerate

    logic [c_LUT_SIZE-1:0] w_tt;
    logic [K-2:0]          w_low_idx;
    logic                  w_sel;
    logic                  w_lutk;
    logic                  w_lo;
    logic                  w_hi;
    logic                  w_out0;
    logic                  w_out1;

    assign w_tt      = r_cfg_q[c_LUT_SIZE-1:0];
    assign w_sel     = r_cfg_q[CFG_LEN-1];
    assign w_low_idx = w_idx[K-2:0];

    // The two halves share the low K-1 inputs. The upper half is addressed
    // by forcing the index MSB high, which is the same as adding H.
    assign w_lutk = w_tt[w_idx];
    assign w_lo   = w_tt[{1'b0, w_low_idx}];
    assign w_hi   = w_tt[{1'b1, w_low_idx}];

    assign w_out0 = w_sel ? w_lutk : w_lo;
    assign w_out1 = w_hi;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfg_done       = (r_cnt_q == c_CNT_DONE);
    assign ccff_tail      = r_cfg_q[CFG_LEN-1];
    assign frac_logic_out = cfg_done ? {w_out0, w_out1} : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_frac_logic_klut_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frac_logic_klut_cfg
//  Description : Scoreboard bench for frac_logic_klut_cfg (K=4). The driver
//                applies one input vector per cycle. After each vector it
//                pushes the response predicted by a behavioural model. A
//                separate monitor pops and compares on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frac_logic_klut_cfg;

    localparam int K = 4;
    localparam int L = 2**K + 1;
    localparam int H = 2**(K-1);

    logic         clk         = 1'b0;
    logic         pReset      = 1'b1;
    logic         ccff_en     = 1'b0;
    logic         cfg_restart = 1'b0;
    logic         ccff_head   = 1'b0;
    logic [0:K-1] frac_logic_in = '0;
    logic [0:1]   frac_logic_out;
    logic         ccff_tail;
    logic         cfg_done;

    frac_logic_klut_cfg #(.K(K)) u_dut (
        .pReset         (pReset),
        .prog_clk       (clk),
        .ccff_en        (ccff_en),
        .cfg_restart    (cfg_restart),
        .ccff_head      (ccff_head),
        .frac_logic_in  (frac_logic_in),
        .frac_logic_out (frac_logic_out),
        .ccff_tail      (ccff_tail),
        .cfg_done       (cfg_done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    // m_cfg[i] is the bit that was shifted in i shifts ago. m_loaded counts
    // bits shifted since the last reset or restart and is never saturated.
    // Anything other than exactly L counts as "not done".
    bit m_cfg [L];
    int m_loaded;

    typedef struct {
        logic o0;
        logic o1;
        logic tail;
        logic done;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   n_issued = 0;

    function automatic void m_clear();
        for (int i = 0; i < L; i++) m_cfg[i] = 1'b0;
        m_loaded = 0;
    endfunction

    // Applies one rising edge using the inputs that were present at the edge.
    function automatic void m_edge(bit en, bit rs, bit head);
        if (en) begin
            for (int i = L-1; i > 0; i--) m_cfg[i] = m_cfg[i-1];
            m_cfg[0] = head;
        end
        if (rs)      m_loaded = en ? 1 : 0;
        else if (en) m_loaded = m_loaded + 1;
    endfunction

    function automatic exp_t m_expect(int idx);
        exp_t e;
        bit   done, sel, lutk, lo, hi;
        done   = (m_loaded == L);
        sel    = m_cfg[2**K];
        lutk   = m_cfg[idx];
        lo     = m_cfg[idx % H];
        hi     = m_cfg[H + (idx % H)];
        e.o0   = done && (sel ? lutk : lo);
        e.o1   = done && hi;
        e.tail = m_cfg[L-1];
        e.done = done;
        e.id   = 0;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic cyc(input bit rst, input bit en, input bit rs,
                       input bit head, input int idx);
        exp_t e;
        @(posedge clk);
        if (!pReset) m_edge(ccff_en, cfg_restart, ccff_head);
        #1;
        pReset      = rst;
        ccff_en     = en;
        cfg_restart = rs;
        ccff_head   = head;
        for (int i = 0; i < K; i++) frac_logic_in[i] = idx[i];
        if (rst) m_clear();
        e    = m_expect(idx);
        e.id = n_issued;
        n_issued++;
        sb.push_back(e);
    endtask

    function automatic int rnd_idx();
        return int'($urandom_range(0, 2**K - 1));
    endfunction

    // Shifts sel first, then the truth table MSB-first. The first shift may
    // carry a restart.
    task automatic load(input bit rs, input bit sel, input logic [15:0] tt);
        logic [15:0] t;
        t = tt;
        cyc(1'b0, 1'b1, rs, sel, rnd_idx());
        for (int b = 15; b >= 0; b--) cyc(1'b0, 1'b1, 1'b0, t[b], rnd_idx());
    endtask

    task automatic sweep();
        for (int i = 0; i < 2**K; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, i);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic act, input logic req,
                       input int id);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b expected %b", name, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            chk("out0", frac_logic_out[0], e.o0,   e.id);
            chk("out1", frac_logic_out[1], e.o1,   e.id);
            chk("tail", ccff_tail,         e.tail, e.id);
            chk("done", cfg_done,          e.done, e.id);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        m_clear();

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 15);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);

        // Full load: sel=1 with 0x8000. Only index 15 drives out0 high.
        load(1'b0, 1'b1, 16'h8000);
        sweep();

        // Fractured mode. The restart carries an enable, so 16 more shifts
        // complete the load.
        load(1'b1, 1'b0, 16'h00FF);
        sweep();
        load(1'b1, 1'b0, 16'hFF00);
        sweep();

        // Overshift by one bit, then restart and reload.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_idx());
        for (int i = 0; i < 18; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_idx());
        sweep();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_idx());
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_idx());
        sweep();

        // Asynchronous reset mid-load. Reset rises 1ns after an edge, so the
        // next falling-edge sample sees it without any rising edge.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_idx());
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, rnd_idx());
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rnd_idx());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_idx());
        load(1'b0, 1'b1, 16'h6996);
        sweep();

        // Chain passthrough: 34 random bits. The model checks ccff_tail.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_idx());
        for (int i = 0; i < 34; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_idx());

        // Random mix of shifts, restarts, idles and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r < 2, $urandom_range(0, 99) < 75, (r >= 2) && (r < 6),
                1'($urandom_range(0, 1)), rnd_idx());
        end

        // Random full loads, each followed by a full index sweep.
        for (int n = 0; n < 4; n++) begin
            load(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            sweep();
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
